// File: rtl/german_home_ctrl.sv
`timescale 1ns/1ps
// Home-node controller for the German coherence protocol: arbitrates Chan1
// requests, sends invalidations and grants over Chan2, absorbs Chan3 InvAcks
// and owns the home memory value.
module german_home_ctrl #(
  parameter int unsigned NODE_NUM   = 3,
  parameter int unsigned DATA_WIDTH = 2,
  parameter int unsigned MEM_INIT   = 0,
  parameter int unsigned PTR_W      = (NODE_NUM > 2) ? $clog2(NODE_NUM) : 1
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [NODE_NUM-1:0]            req_valid,
  input  logic [NODE_NUM-1:0]            req_excl,
  output logic [NODE_NUM-1:0]            req_ready,
  output logic [NODE_NUM-1:0]            c2_valid,
  output logic [3*NODE_NUM-1:0]          c2_cmd,
  output logic [DATA_WIDTH*NODE_NUM-1:0] c2_data,
  input  logic [NODE_NUM-1:0]            c2_ready,
  input  logic [NODE_NUM-1:0]            ack_valid,
  input  logic [DATA_WIDTH*NODE_NUM-1:0] ack_data,
  output logic [NODE_NUM-1:0]            ack_ready,
  output logic [2:0]                     cur_cmd,
  output logic [PTR_W-1:0]               cur_ptr,
  output logic                           ex_gntd,
  output logic [NODE_NUM-1:0]            shr_set,
  output logic [NODE_NUM-1:0]            inv_set,
  output logic [DATA_WIDTH-1:0]          mem_data,
  output logic                           proto_err
);

  localparam logic [2:0] CMD_EMPTY = 3'd0;
  localparam logic [2:0] CMD_REQ_S = 3'd1;
  localparam logic [2:0] CMD_REQ_E = 3'd2;
  localparam logic [2:0] MSG_INV   = 3'd3;
  localparam logic [2:0] MSG_GNT_S = 3'd5;
  localparam logic [2:0] MSG_GNT_E = 3'd6;
  localparam logic [PTR_W:0] NODE_CNT = (PTR_W+1)'(NODE_NUM);

  logic [PTR_W-1:0]      rr_q, rr_d;
  logic [2:0]            slot_cmd_q  [NODE_NUM];
  logic [2:0]            slot_cmd_d  [NODE_NUM];
  logic [DATA_WIDTH-1:0] slot_data_q [NODE_NUM];
  logic [DATA_WIDTH-1:0] slot_data_d [NODE_NUM];

  logic [2:0]            cur_cmd_d;
  logic [PTR_W-1:0]      cur_ptr_d;
  logic                  ex_gntd_d;
  logic [NODE_NUM-1:0]   shr_set_d;
  logic [NODE_NUM-1:0]   inv_set_d;
  logic [DATA_WIDTH-1:0] mem_data_d;
  logic                  proto_err_d;
  logic [NODE_NUM-1:0]   c2_valid_d;

  logic [NODE_NUM-1:0]   slot_free;
  logic [NODE_NUM-1:0]   ack_acc;
  logic [NODE_NUM-1:0]   ack_bad;
  logic [DATA_WIDTH-1:0] ack_lo_data;
  logic                  req_fire;
  logic [PTR_W-1:0]      win_idx;
  logic                  win_found;
  logic [PTR_W:0]        rr_sum;
  logic                  inv_en;
  logic                  inv_fire;
  logic [PTR_W-1:0]      inv_idx;
  logic                  inv_hits_ptr;
  logic                  gnt_s;
  logic                  gnt_e;

  // Flatten per-node Chan2 slots onto the output buses
  for (genvar g = 0; g < NODE_NUM; g++) begin : g_pack
    assign c2_cmd[3*g +: 3]                   = slot_cmd_q[g];
    assign c2_data[DATA_WIDTH*g +: DATA_WIDTH] = slot_data_q[g];
  end

  // Decide this cycle's actions from registered state: arbitration, Inv, acks, grants
  always_comb begin
    slot_free   = ~c2_valid | c2_ready;
    win_found   = 1'b0;
    win_idx     = '0;
    rr_sum      = '0;
    for (int unsigned k = 1; k <= NODE_NUM; k++) begin
      rr_sum = {1'b0, rr_q} + (PTR_W+1)'(k);
      if (rr_sum >= NODE_CNT) rr_sum = rr_sum - NODE_CNT;
      if (!win_found && req_valid[rr_sum[PTR_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = rr_sum[PTR_W-1:0];
      end
    end
    req_fire  = (cur_cmd == CMD_EMPTY) && win_found;
    req_ready = '0;
    if (req_fire) req_ready[win_idx] = 1'b1;

    ack_ready   = (cur_cmd != CMD_EMPTY) ? shr_set : '0;
    ack_acc     = ack_valid & ack_ready;
    ack_bad     = ack_valid & ~ack_ready;
    ack_lo_data = '0;
    for (int i = NODE_NUM - 1; i >= 0; i--) begin
      if (ack_acc[i]) ack_lo_data = ack_data[i*DATA_WIDTH +: DATA_WIDTH];
    end

    inv_en   = (cur_cmd == CMD_REQ_E) || ((cur_cmd == CMD_REQ_S) && ex_gntd);
    inv_fire = 1'b0;
    inv_idx  = '0;
    for (int unsigned i = 0; i < NODE_NUM; i++) begin
      if (inv_en && !inv_fire && inv_set[i] && slot_free[i]) begin
        inv_fire = 1'b1;
        inv_idx  = PTR_W'(i);
      end
    end

    // An Inv to the requester's slot takes it this cycle; the grant waits
    inv_hits_ptr = inv_fire && (inv_idx == cur_ptr);
    gnt_s = (cur_cmd == CMD_REQ_S) && !ex_gntd && slot_free[cur_ptr] && !inv_hits_ptr;
    gnt_e = (cur_cmd == CMD_REQ_E) && !ex_gntd && (shr_set == '0) &&
            slot_free[cur_ptr] && !inv_hits_ptr;
  end

  // Next-state of directory, memory and Chan2 slots
  always_comb begin
    cur_cmd_d   = cur_cmd;
    cur_ptr_d   = cur_ptr;
    ex_gntd_d   = ex_gntd;
    inv_set_d   = inv_set;
    mem_data_d  = mem_data;
    rr_d        = rr_q;
    c2_valid_d  = c2_valid;
    slot_cmd_d  = slot_cmd_q;
    slot_data_d = slot_data_q;
    shr_set_d   = shr_set & ~ack_acc;
    proto_err_d = proto_err | (|ack_bad);

    for (int unsigned i = 0; i < NODE_NUM; i++) begin
      if (c2_valid[i] && c2_ready[i]) begin
        c2_valid_d[i]  = 1'b0;
        slot_cmd_d[i]  = CMD_EMPTY;
        slot_data_d[i] = '0;
      end
    end

    if (req_fire) begin
      cur_cmd_d = req_excl[win_idx] ? CMD_REQ_E : CMD_REQ_S;
      cur_ptr_d = win_idx;
      inv_set_d = shr_set;
      rr_d      = win_idx;
    end

    if (inv_fire) begin
      inv_set_d[inv_idx]   = 1'b0;
      c2_valid_d[inv_idx]  = 1'b1;
      slot_cmd_d[inv_idx]  = MSG_INV;
      slot_data_d[inv_idx] = '0;
    end

    if (ex_gntd && (|ack_acc)) begin
      ex_gntd_d  = 1'b0;
      mem_data_d = ack_lo_data;
    end

    if (gnt_s || gnt_e) begin
      c2_valid_d[cur_ptr]  = 1'b1;
      slot_cmd_d[cur_ptr]  = gnt_e ? MSG_GNT_E : MSG_GNT_S;
      slot_data_d[cur_ptr] = mem_data;
      shr_set_d[cur_ptr]   = 1'b1;
      cur_cmd_d            = CMD_EMPTY;
      if (gnt_e) ex_gntd_d = 1'b1;
    end
  end

  // State register with asynchronous reset
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cur_cmd   <= CMD_EMPTY;
      cur_ptr   <= '0;
      ex_gntd   <= 1'b0;
      shr_set   <= '0;
      inv_set   <= '0;
      mem_data  <= DATA_WIDTH'(MEM_INIT);
      proto_err <= 1'b0;
      rr_q      <= '0;
      c2_valid  <= '0;
      for (int unsigned i = 0; i < NODE_NUM; i++) begin
        slot_cmd_q[i]  <= CMD_EMPTY;
        slot_data_q[i] <= '0;
      end
    end else begin
      cur_cmd     <= cur_cmd_d;
      cur_ptr     <= cur_ptr_d;
      ex_gntd     <= ex_gntd_d;
      shr_set     <= shr_set_d;
      inv_set     <= inv_set_d;
      mem_data    <= mem_data_d;
      proto_err   <= proto_err_d;
      rr_q        <= rr_d;
      c2_valid    <= c2_valid_d;
      slot_cmd_q  <= slot_cmd_d;
      slot_data_q <= slot_data_d;
    end
  end

endmodule

// File: tb/tb_german_home_ctrl.sv
`timescale 1ns/1ps
// Self-checking bench for german_home_ctrl: directed protocol scenarios plus
// randomized traffic, compared every cycle against a rule-level home model.
module tb_german_home_ctrl;

  localparam int N  = 3;
  localparam int DW = 2;
  localparam int MI = 2;
  localparam int PW = 2;

  logic            clock;
  logic            reset;
  logic [N-1:0]    req_valid, req_excl, req_ready;
  logic [N-1:0]    c2_valid, c2_ready;
  logic [3*N-1:0]  c2_cmd;
  logic [DW*N-1:0] c2_data;
  logic [N-1:0]    ack_valid, ack_ready;
  logic [DW*N-1:0] ack_data;
  logic [2:0]      cur_cmd;
  logic [PW-1:0]   cur_ptr;
  logic            ex_gntd;
  logic [N-1:0]    shr_set, inv_set;
  logic [DW-1:0]   mem_data;
  logic            proto_err;

  german_home_ctrl #(.NODE_NUM(N), .DATA_WIDTH(DW), .MEM_INIT(MI)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_excl(req_excl), .req_ready(req_ready),
    .c2_valid(c2_valid), .c2_cmd(c2_cmd), .c2_data(c2_data), .c2_ready(c2_ready),
    .ack_valid(ack_valid), .ack_data(ack_data), .ack_ready(ack_ready),
    .cur_cmd(cur_cmd), .cur_ptr(cur_ptr), .ex_gntd(ex_gntd),
    .shr_set(shr_set), .inv_set(inv_set), .mem_data(mem_data), .proto_err(proto_err)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int vectors = 0;
  int errs    = 0;

  // Reference home: directory and channel state kept as plain ints/bits
  int m_cmd, m_ptr, m_rr, m_mem;
  bit m_ex, m_err;
  bit m_shr [N];
  bit m_inv [N];
  bit m_cv  [N];
  int m_cc  [N];
  int m_cd  [N];

  logic [N-1:0] last_req_ready, last_ack_ready;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cmd = 0; m_ptr = 0; m_rr = 0; m_mem = MI; m_ex = 0; m_err = 0;
    for (int i = 0; i < N; i++) begin
      m_shr[i] = 0; m_inv[i] = 0; m_cv[i] = 0; m_cc[i] = 0; m_cd[i] = 0;
    end
  endtask

  task automatic check_regs(input string pfx);
    logic [N-1:0]    e_cv, e_shr, e_inv;
    logic [3*N-1:0]  e_cc;
    logic [DW*N-1:0] e_cd;
    for (int i = 0; i < N; i++) begin
      e_cv[i] = m_cv[i]; e_shr[i] = m_shr[i]; e_inv[i] = m_inv[i];
      e_cc[i*3 +: 3]   = 3'(m_cc[i]);
      e_cd[i*DW +: DW] = DW'(m_cd[i]);
    end
    chk({pfx, "c2_valid"}, 64'(c2_valid), 64'(e_cv));
    chk({pfx, "c2_cmd"},   64'(c2_cmd),   64'(e_cc));
    chk({pfx, "c2_data"},  64'(c2_data),  64'(e_cd));
    chk({pfx, "cur_cmd"},  64'(cur_cmd),  64'(m_cmd));
    chk({pfx, "cur_ptr"},  64'(cur_ptr),  64'(m_ptr));
    chk({pfx, "ex_gntd"},  64'(ex_gntd),  64'(m_ex));
    chk({pfx, "shr_set"},  64'(shr_set),  64'(e_shr));
    chk({pfx, "inv_set"},  64'(inv_set),  64'(e_inv));
    chk({pfx, "mem_data"}, 64'(mem_data), 64'(m_mem));
    chk({pfx, "proto_err"},64'(proto_err),64'(m_err));
  endtask

  task automatic check_all();
    logic [N-1:0] e_req, e_ack;
    e_req = '0;
    if (m_cmd == 0) begin
      for (int k = 1; k <= N; k++) begin
        if (req_valid[(m_rr + k) % N]) begin
          e_req[(m_rr + k) % N] = 1'b1;
          break;
        end
      end
    end
    for (int i = 0; i < N; i++) e_ack[i] = (m_cmd != 0) && m_shr[i];
    last_req_ready = req_ready;
    last_ack_ready = ack_ready;
    chk("req_ready", 64'(req_ready), 64'(e_req));
    chk("ack_ready", 64'(ack_ready), 64'(e_ack));
    check_regs("");
  endtask

  // One clock of protocol rules applied to the reference state
  task automatic model_step();
    bit free [N];
    int inv_t = -1, win = -1, gcmd = 0, first_ack = -1;
    bit gnt = 0, any_shr = 0;
    for (int i = 0; i < N; i++) begin
      free[i] = !m_cv[i] || c2_ready[i];
      any_shr |= m_shr[i];
    end
    if (m_cmd == 2 || (m_cmd == 1 && m_ex))
      for (int i = 0; i < N; i++)
        if (m_inv[i] && free[i]) begin inv_t = i; break; end
    if (m_cmd != 0 && !m_ex && free[m_ptr] && inv_t != m_ptr) begin
      if (m_cmd == 1) begin gnt = 1; gcmd = 5; end
      else if (m_cmd == 2 && !any_shr) begin gnt = 1; gcmd = 6; end
    end
    if (m_cmd == 0)
      for (int k = 1; k <= N; k++)
        if (req_valid[(m_rr + k) % N]) begin win = (m_rr + k) % N; break; end

    for (int i = 0; i < N; i++)
      if (m_cv[i] && c2_ready[i]) begin m_cv[i] = 0; m_cc[i] = 0; m_cd[i] = 0; end
    if (inv_t >= 0) begin
      m_cv[inv_t] = 1; m_cc[inv_t] = 3; m_cd[inv_t] = 0; m_inv[inv_t] = 0;
    end
    if (gnt) begin
      m_cv[m_ptr] = 1; m_cc[m_ptr] = gcmd; m_cd[m_ptr] = m_mem;
    end
    for (int i = 0; i < N; i++) begin
      if (ack_valid[i]) begin
        if (m_cmd != 0 && m_shr[i]) begin
          if (first_ack < 0) first_ack = i;
          m_shr[i] = 0;
        end else begin
          m_err = 1;
        end
      end
    end
    if (m_ex && first_ack >= 0) begin
      m_ex  = 0;
      m_mem = int'(ack_data[first_ack*DW +: DW]);
    end
    if (gnt) begin
      m_shr[m_ptr] = 1;
      m_cmd = 0;
      if (gcmd == 6) m_ex = 1;
    end
    if (win >= 0) begin
      for (int i = 0; i < N; i++) m_inv[i] = m_shr[i];
      m_cmd = req_excl[win] ? 2 : 1;
      m_ptr = win;
      m_rr  = win;
    end
  endtask

  task automatic step_cycle();
    #1;
    check_all();
    model_step();
    @(negedge clock);
  endtask

  // Asserted away from any clock edge, so reset must act asynchronously
  task automatic apply_reset();
    reset = 1'b1;
    #1;
    model_reset();
    check_regs("rst_");
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic idle_inputs();
    req_valid = '0; req_excl = '0; c2_ready = '0; ack_valid = '0; ack_data = '0;
  endtask

  int order [3];
  int nwin;

  initial begin
    reset = 1'b1;
    idle_inputs();
    model_reset();
    @(negedge clock);
    apply_reset();

    // ReqS from node1 on an idle system: accept at N, GntS visible at N+2
    req_valid = 3'b010;
    step_cycle();
    chk("acc_cycle0", 64'(last_req_ready), 64'(3'b010));
    req_valid = '0;
    step_cycle();
    chk("gnts_valid_n2", 64'(c2_valid), 64'(3'b010));
    chk("gnts_cmd_n2",   64'(c2_cmd[5:3]), 64'(5));
    chk("gnts_data_n2",  64'(c2_data[3:2]), 64'(MI));
    chk("gnts_shr_n2",   64'(shr_set), 64'(3'b010));
    chk("gnts_cmd_idle", 64'(cur_cmd), 64'(0));

    // Second ReqS to node1 while its slot still holds the first GntS
    req_valid = 3'b010;
    step_cycle();
    req_valid = '0;
    repeat (3) step_cycle();
    chk("stall_cur_cmd", 64'(cur_cmd), 64'(1));
    chk("stall_slot_kept", 64'(c2_cmd[5:3]), 64'(5));
    c2_ready = 3'b010;
    step_cycle();
    c2_ready = '0;
    chk("stall_released", 64'(cur_cmd), 64'(0));
    chk("stall_refilled", 64'(c2_valid[1]), 64'(1));
    step_cycle();

    // All three nodes requesting from reset: round-robin order 1, 2, 0
    apply_reset();
    req_valid = 3'b111;
    c2_ready  = 3'b111;
    order = '{-1, -1, -1};
    nwin  = 0;
    for (int c = 0; c < 12 && nwin < 3; c++) begin
      step_cycle();
      for (int i = 0; i < N; i++)
        if (last_req_ready[i]) begin order[nwin] = i; nwin++; end
    end
    chk("rr_first",  64'(order[0]), 64'(1));
    chk("rr_second", 64'(order[1]), 64'(2));
    chk("rr_third",  64'(order[2]), 64'(0));
    idle_inputs();

    // Stray InvAck with no transaction in flight: refused, error sticks
    apply_reset();
    ack_valid = 3'b100;
    ack_data  = 6'b01_00_00;
    step_cycle();
    chk("bad_ack_ready", 64'(last_ack_ready[2]), 64'(0));
    chk("err_set", 64'(proto_err), 64'(1));
    ack_valid = '0;
    repeat (3) step_cycle();
    chk("err_sticky", 64'(proto_err), 64'(1));
    apply_reset();
    chk("err_cleared", 64'(proto_err), 64'(0));

    // Randomized traffic driven by reference state (acks follow consumed Invs)
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 299) == 0) apply_reset();
      req_valid = N'($urandom);
      for (int i = 0; i < N; i++) req_excl[i] = ($urandom_range(0, 9) < 4);
      c2_ready  = '0;
      for (int i = 0; i < N; i++) c2_ready[i] = ($urandom_range(0, 9) < 6);
      ack_data  = (DW*N)'($urandom);
      ack_valid = '0;
      for (int i = 0; i < N; i++)
        if (m_cmd != 0 && m_shr[i] && !m_inv[i] && !(m_cv[i] && m_cc[i] == 3))
          ack_valid[i] = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 59) == 0) ack_valid[$urandom_range(0, N-1)] = 1'b1;
      step_cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule

// File: doc/german_home_ctrl.md
Name: german_home_ctrl

Overview:
- Parametrised home-node controller for the German cache-coherence protocol.
- Generalises the fixed 3-cache system to NODE_NUM caches and DATA_WIDTH-bit data.
- Adds real valid/ready channels, round-robin request arbitration and a sticky protocol-error flag.
- Sits between the per-cache channel fabric (Chan1/Chan2/Chan3) and the memory data register. One instance per home.

Parameters:
NODE_NUM, 3, number of caches (>=2)
DATA_WIDTH, 2, width of a cache line datum
MEM_INIT, 0, reset value of mem_data
PTR_W, max(1,$clog2(NODE_NUM)), width of cur_ptr (derived)

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
req_valid  in  NODE_NUM  Chan1 request present, per node
req_excl  in  NODE_NUM  1=ReqE, 0=ReqS
req_ready  out  NODE_NUM  request accepted this cycle (one-hot or zero)
c2_valid  out  NODE_NUM  Chan2 message pending, per node
c2_cmd  out  3*NODE_NUM  Chan2 command (Inv=3, GntS=5, GntE=6, Empty=0)
c2_data  out  DATA_WIDTH*NODE_NUM  Chan2 data (grants only, else 0)
c2_ready  in  NODE_NUM  cache consumes Chan2 message
ack_valid  in  NODE_NUM  Chan3 InvAck present
ack_data  in  DATA_WIDTH*NODE_NUM  InvAck data (dirty line from exclusive owner)
ack_ready  out  NODE_NUM  InvAck accepted
cur_cmd  out  3  current request (Empty=0, ReqS=1, ReqE=2)
cur_ptr  out  PTR_W  requesting node
ex_gntd  out  1  exclusive copy granted
shr_set  out  NODE_NUM  sharer vector
inv_set  out  NODE_NUM  invalidations still to send
mem_data  out  DATA_WIDTH  home memory value
proto_err  out  1  sticky protocol-violation flag

Behaviour:
- Reset (async, immediate): cur_cmd=0, cur_ptr=0, ex_gntd=0, shr_set=0, inv_set=0, mem_data=MEM_INIT, all c2_valid=0, c2_cmd=0, c2_data=0, proto_err=0, rr pointer=0. Reset mid-transaction discards everything, including pending Chan2 messages.
- Chan2 slot per node: holds its message while c2_valid=1 until c2_ready=1. Slot free = !c2_valid | c2_ready; a freed slot is refillable the same cycle.
- RecvReq: only when cur_cmd==0. Round-robin over req_valid, starting at rr+1; the winner gets req_ready=1.
  - Next cycle: cur_cmd = req_excl?2:1, cur_ptr=winner, inv_set=shr_set, rr=winner.
  - req_ready=0 for all nodes whenever cur_cmd!=0.
- SendInv: needs cur_cmd==2, or (cur_cmd==1 & ex_gntd). Lowest-index i with inv_set[i] & slot i free -> c2 slot i = Inv, data 0; inv_set[i] cleared. At most one Inv per cycle.
- RecvInvAck: ack_ready[i] = (cur_cmd!=0) & shr_set[i]. All ready acks are accepted in parallel.
  - Each accepted ack clears shr_set[i].
  - If ex_gntd: ex_gntd<=0 and mem_data<=ack_data of the lowest accepted index.
  - ack_valid[i] with cur_cmd==0 or shr_set[i]==0 -> ack_ready[i]=0 and proto_err<=1. Such acks are never consumed.
- SendGntS: cur_cmd==1 & !ex_gntd & slot[cur_ptr] free -> GntS, mem_data to node cur_ptr; shr_set[cur_ptr]<=1; cur_cmd<=0.
- SendGntE: cur_cmd==2 & !ex_gntd & shr_set==0 & slot[cur_ptr] free -> GntE, mem_data; shr_set[cur_ptr]<=1; ex_gntd<=1; cur_cmd<=0.
- All decisions use registered state. The earliest grant comes the cycle after the last ack clears shr_set/ex_gntd.
- Same-cycle events:
  - SendInv and a grant never target the same slot. Inv takes priority; grant waits.
  - SendInv and RecvInvAck may coincide.
- Latency, ReqS with no exclusive owner: accept cycle N, GntS valid cycle N+2.
- Slot contention: a new message is never written into a slot that is not free.

Test Plan:
- ReqS node1, idle system, mem_data=2 -> req_ready[1] cycle 0; c2 node1 = GntS data 2 at cycle 2; shr_set=3'b010, cur_cmd=0.
- ReqE node0 with shr_set=3'b110 -> Inv to node1 then node2 on consecutive cycles; acks clear shr_set; GntE to node0 the cycle after shr_set==0; ex_gntd=1.
- ex_gntd=1, owner node1, ReqS node2, owner ack_data=1 -> mem_data=1, ex_gntd=0, GntS data 1 to node2.
- req_valid=3'b111 held over three transactions from reset -> served in order 1, 2, 0 (round-robin).
- c2_ready[0]=0 holding an earlier GntS in slot 0; next grant to node0 -> grant stalls until c2_ready[0]=1, then issued; no message lost.
- ack_valid[2]=1 with cur_cmd=0 -> ack_ready[2]=0, proto_err=1 and stays 1; reset clears it asynchronously.
